// File: rtl/aes_block_gather_pkg.sv
// Shared AES types for the input-side gather stage: block type, words per
// block and the gather FSM state encoding.
package aes_block_gather_pkg;

  localparam int AES_WORDS_PER_BLOCK = 4;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } gather_state_e;

endpackage

// File: rtl/aes_block_gather.sv
// Packs 32-bit streamer words into 128-bit AES blocks (first word in the MSBs),
// hands each block to the core and counts blocks against the job length.
module aes_block_gather
  import aes_block_gather_pkg::*;
#(
  parameter int WORD_W          = 32,
  parameter int WORDS_PER_BLOCK = AES_WORDS_PER_BLOCK,
  parameter int CNT_W           = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [CNT_W-1:0]     n_blocks_i,
  input  logic                 word_valid_i,
  output logic                 word_ready_o,
  input  logic [WORD_W-1:0]    word_data_i,
  output logic                 blk_valid_o,
  input  logic                 blk_ready_i,
  output aes_block_t           blk_data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_W-1:0]     blk_cnt_o,
  output gather_state_e        state_o
);

  // Handshakes: a transfer happens on the rising edge where valid and ready
  // are both high; valid never waits on ready and data is stable while valid.

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  gather_state_e    state, state_n;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] len;
  logic             word_acc;
  logic             blk_acc;
  logic             last_word;
  logic             last_blk;

  assign state_o = state;

  always_comb begin
    state_n      = state;
    word_ready_o = (state == FILL);
    word_acc     = word_valid_i && (state == FILL);
    blk_acc      = blk_valid_o && blk_ready_i;
    last_word    = (idx == IDX_LAST);
    last_blk     = ((blk_cnt_o + CNT_ONE) == len);
    case (state)
      IDLE: if (start_i && (n_blocks_i != '0)) state_n = FILL;
      FILL: if (word_acc && last_word) state_n = HOLD;
      HOLD: if (blk_acc) state_n = last_blk ? IDLE : FILL;
      default: state_n = IDLE;
    endcase
    if (clear_i) state_n = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      idx         <= '0;
      len         <= '0;
      blk_valid_o <= 1'b0;
      blk_data_o  <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      blk_cnt_o   <= '0;
    end else if (clear_i) begin
      state       <= IDLE;
      idx         <= '0;
      len         <= '0;
      blk_valid_o <= 1'b0;
      blk_data_o  <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      blk_cnt_o   <= '0;
    end else begin
      state       <= state_n;
      blk_valid_o <= (state_n == HOLD);
      busy_o      <= (state_n != IDLE);
      done_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            len       <= n_blocks_i;
            blk_cnt_o <= '0;
            idx       <= '0;
            // Zero-length job completes immediately without leaving IDLE.
            if (n_blocks_i == '0) done_o <= 1'b1;
          end
        end
        FILL: begin
          if (word_acc) begin
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
              if (idx == IDX_W'(i))
                blk_data_o[(WORDS_PER_BLOCK-1-i)*WORD_W +: WORD_W] <= word_data_i;
            end
            idx <= last_word ? '0 : idx + IDX_ONE;
          end
        end
        HOLD: begin
          if (blk_acc) begin
            blk_cnt_o <= blk_cnt_o + CNT_ONE;
            if (last_blk) done_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/aes_block_gather.md
# aes_block_gather

Input-side packing stage of the AES engine, directly downstream of the AES control unit's streamer/engine control path. Accepts 32-bit words from the streamer source and assembles them into 128-bit AES state blocks. Presents each block to the AES core with a valid/ready handshake. Counts blocks against the job length programmed by the control FSM and returns a done pulse, used as an engine flag.

## Interface
- `WORD_W`, 32: streamer word width; fixed at 32 for this block.
- `WORDS_PER_BLOCK`, 4: words per AES block (`AES_WORDS_PER_BLOCK`).
- `CNT_W`, 16: width of block-count length and counter.

Ports:
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `clear_i`  in  1  synchronous soft clear from control (clear output of the control unit).
- `start_i`  in  1  single-cycle job start pulse.
- `n_blocks_i`  in  CNT_W  number of blocks in the job; sampled on `start_i`.
- `word_valid_i`  in  1  streamer word valid.
- `word_ready_o`  out  1  word accepted when valid and ready.
- `word_data_i`  in  32  streamer word.
- `blk_valid_o`  out  1  assembled block valid.
- `blk_ready_i`  in  1  AES core ready.
- `blk_data_o`  out  128  assembled block.
- `busy_o`  out  1  job in progress.
- `done_o`  out  1  one-cycle pulse at job end.
- `blk_cnt_o`  out  CNT_W  blocks delivered in the current/last job.

## Operation
- Reset (`rst_i`) values: state IDLE, `word_ready_o`=0, `blk_valid_o`=0, `blk_data_o`=0, `busy_o`=0, `done_o`=0, `blk_cnt_o`=0, word index=0.
- IDLE:
  - `start_i` with `n_blocks_i`≠0: latch length, clear `blk_cnt_o` and word index, go to FILL.
  - `start_i` with `n_blocks_i`=0: `done_o` pulses next cycle and the block stays in IDLE with `blk_cnt_o`=0.
- FILL:
  - `word_ready_o`=1.
  - Each accepted word is written at index i (0..3) into bits [127-32i -: 32]; the first word lands in [127:96].
  - On acceptance of the 4th word, go to HOLD and reset the index.
- HOLD:
  - `word_ready_o`=0 and `blk_valid_o`=1.
  - `blk_data_o` is held stable until the handshake.
  - On `blk_valid_o`&`blk_ready_i`, `blk_cnt_o` increments.
  - If the new count equals the latched length, go to IDLE and pulse `done_o`; otherwise go to FILL.
- `busy_o`=1 in FILL and HOLD.
- `start_i` outside IDLE is ignored.
- Words presented in IDLE or HOLD are not accepted.
- `clear_i` has priority over every transition and resets all state and outputs to their reset values. It produces no `done_o`.
- `blk_cnt_o` never wraps: it stops at the latched length (max 2^CNT_W−1). It holds its final value until the next `start_i` or clear.

## Timing
- All outputs are registered, except `word_ready_o`, which is decoded from state.
- Word handshake completes at a rising edge with `word_valid_i`&`word_ready_o`.
- If the 4th word is accepted at edge k, `blk_valid_o`=1 from cycle k+1.
- If the block handshake occurs at edge m:
  - with blocks remaining, `word_ready_o`=1 from cycle m+1;
  - on the last block, `done_o`=1 during cycle m+1 only and `busy_o`=0 from m+1.
- `start_i` at edge s gives `busy_o`=1 and `word_ready_o`=1 from s+1.
- Minimum period is 5 cycles per block (4 fill + 1 hold) with no stalls.
- Back-pressure via `blk_ready_i`=0 holds HOLD indefinitely with data stable.
- Asynchronous reset mid-job aborts immediately. A partially filled block is discarded.

## Structure
- In the shared AES package:
  - `aes_block_t` (logic [127:0]);
  - `AES_WORDS_PER_BLOCK`=4;
  - gather state enum {IDLE, FILL, HOLD}.
- A single module; no sub-module.

## Test plan
- Basic job: `n_blocks_i`=1, words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with `blk_ready_i`=1 -> `blk_data_o`=0x00112233_44556677_8899AABB_CCDDEEFF; `done_o` 1 cycle after the handshake; `blk_cnt_o`=1.
- Multi-block with streamer gaps: `n_blocks_i`=3 with random `word_valid_i` gaps -> three blocks in order, `blk_cnt_o`=3, exactly one `done_o` pulse.
- Back-pressure: `blk_ready_i`=0 for 10 cycles in HOLD -> `blk_data_o` stable, `word_ready_o`=0, then handshake proceeds.
- Zero length: `start_i` with `n_blocks_i`=0 -> `done_o` pulse next cycle, `busy_o` never 1, no words accepted.
- Clear and ignored start: assert `clear_i` after 2 words of block 2 -> all outputs at reset values, no `done_o`. Then a `start_i` during the new job's FILL is ignored.
- Async reset: assert `rst_i` mid-HOLD between edges -> outputs go to reset values without waiting for an edge; a subsequent job completes normally.
